// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial adder/subtractor, LSB first, WIDTH cycles per operation.
// Controller (IDLE/RUN/DONE) and shift-register datapath share one block.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Mrst,
    input  logic             go,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [1:0]       STATE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    // Full-adder slice on the current LSBs plus the end-of-operation detect
    always_comb begin
        s_bit    = op_a[0] ^ op_b[0] ^ carry;
        c_next   = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Next-state logic; the unused encoding 11 falls back to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = go ? S_RUN : S_IDLE;
            S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_d = go ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (Mrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand load on go, one result bit per RUN cycle, flags on the last bit
    always_ff @(posedge clk) begin
        if (Mrst) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry
                        op_a   <= acc ? sum_r : a;
                        op_b   <= sub ? ~b : b;
                        carry  <= sub;
                        cnt    <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                    end
                end
                S_RUN: begin
                    sum_r <= {s_bit, sum_r[WIDTH-1:1]};
                    op_a  <= {1'b0, op_a[WIDTH-1:1]};
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cout_r <= c_next;
                        ovf_r  <= carry ^ c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode directly from registers
    always_comb begin
        sum   = sum_r;
        cout  = cout_r;
        ovf   = ovf_r;
        busy  = (state_q == S_RUN);
        done  = (state_q == S_DONE);
        STATE = state_q;
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Testbench for serial_addsub_unit: directed vector table, randomized ops against an
// arithmetic reference model, plus reset/handshake sequences and a 16-bit instance.
module tb_serial_addsub_unit;

    logic        clk;
    logic        mrst;

    logic        go8, sub8, acc8;
    logic [7:0]  a8, b8, sum8;
    logic        cout8, ovf8, busy8, done8;
    logic [1:0]  state8;

    logic        go16, sub16, acc16;
    logic [15:0] a16, b16, sum16;
    logic        cout16, ovf16, busy16, done16;
    logic [1:0]  state16;

    int pass_cnt;
    int total_cnt;

    serial_addsub_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .Mrst(mrst), .go(go8), .sub(sub8), .acc(acc8),
        .a(a8), .b(b8), .sum(sum8), .cout(cout8), .ovf(ovf8),
        .busy(busy8), .done(done8), .STATE(state8)
    );

    serial_addsub_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .Mrst(mrst), .go(go16), .sub(sub16), .acc(acc16),
        .a(a16), .b(b16), .sum(sum16), .cout(cout16), .ovf(ovf16),
        .busy(busy16), .done(done16), .STATE(state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sub;
        logic       acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain modular arithmetic on integers, flags from operand/result signs
    task automatic model(input int w, input logic s, input longint unsigned av, input longint unsigned bv,
                         output longint unsigned res, output logic c, output logic o);
        longint unsigned mask;
        longint unsigned full;
        logic sa, sb, sr;
        mask = (64'd1 << w) - 1;
        if (!s) begin
            full = av + bv;
            res  = full & mask;
            c    = full[w];
        end else begin
            res = (av - bv) & mask;
            c   = (av >= bv);
        end
        sa = av[w-1];
        sb = bv[w-1];
        sr = res[w-1];
        if (!s) o = (sa == sb) && (sr != sa);
        else    o = (sa != sb) && (sr != sa);
    endtask

    // Start an 8-bit op with go held high; returns when done is seen or the bound expires
    task automatic run8(input logic s, input logic ac, input logic [7:0] av, input logic [7:0] bv,
                        input bit toggle, output int lat);
        go8 = 1'b1; sub8 = s; acc8 = ac; a8 = av; b8 = bv;
        @(posedge clk); #1;
        chk("busy_after_go", busy8, 1);
        lat = 0;
        while (!done8 && lat < 50) begin
            if (toggle) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom); acc8 = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Release go from DONE; IDLE must follow on the next edge
    task automatic release8();
        go8 = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_release", state8, 0);
    endtask

    vec_t            vecs[7];
    int              lat;
    longint unsigned m_sum;
    longint unsigned exp_res;
    logic            exp_c, exp_o;
    logic            r_sub, r_acc;
    logic [7:0]      r_a, r_b;

    initial begin
        pass_cnt = 0; total_cnt = 0;
        vecs[0] = '{1'b0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hAA, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 8'h80, 8'hFF, 1'b0, 1'b1};

        mrst = 1'b1;
        go8 = 0; sub8 = 0; acc8 = 0; a8 = '0; b8 = '0;
        go16 = 0; sub16 = 0; acc16 = 0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_flags", {cout8, ovf8, busy8, done8}, 0);
        chk("rst_state16", state16, 0);
        mrst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, including accumulate chains on the previous result
        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].sub, vecs[i].acc, vecs[i].a, vecs[i].b, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), lat, 8);
            chk($sformatf("vec%0d_sum", i), sum8, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), cout8, vecs[i].cout);
            chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
            release8();
        end
        m_sum = 64'(vecs[6].sum);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            r_sub = 1'($urandom); r_acc = 1'($urandom);
            r_a = 8'($urandom);   r_b = 8'($urandom);
            model(8, r_sub, r_acc ? m_sum : 64'(r_a), 64'(r_b), exp_res, exp_c, exp_o);
            run8(r_sub, r_acc, r_a, r_b, 1'b0, lat);
            chk("rand_latency", lat, 8);
            chk("rand_result", {cout8, ovf8, sum8}, {exp_c, exp_o, 8'(exp_res)});
            m_sum = exp_res;
            release8();
        end

        // Reset during the 4th RUN cycle, with go still high: reset wins
        go8 = 1'b1; sub8 = 0; acc8 = 0; a8 = 8'h5A; b8 = 8'h33;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrun_busy", busy8, 1);
        mrst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_state", state8, 0);
        chk("midrst_sum", sum8, 0);
        chk("midrst_busy_done", {busy8, done8}, 0);
        chk("midrst_flags", {cout8, ovf8}, 0);
        mrst = 1'b0; go8 = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", state8, 0);
        run8(1'b0, 1'b1, 8'hEE, 8'h05, 1'b0, lat);
        chk("post_rst_acc_sum", sum8, 8'h05);
        release8();
        run8(1'b0, 1'b0, 8'h12, 8'h34, 1'b0, lat);
        chk("post_rst_sum", sum8, 8'h46);
        release8();

        // Inputs toggled during RUN are ignored; go held in DONE does not retrigger
        run8(1'b0, 1'b0, 8'h01, 8'h02, 1'b1, lat);
        chk("toggle_latency", lat, 8);
        chk("toggle_sum", sum8, 8'h03);
        go8 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("done_hold_state", state8, 2);
        chk("done_hold_sum", sum8, 8'h03);
        release8();
        @(posedge clk); #1;
        chk("idle_stays", state8, 0);

        // 16-bit instance: carry out of the full width
        go16 = 1'b1; sub16 = 0; acc16 = 0; a16 = 16'hFFFF; b16 = 16'h0001;
        @(posedge clk); #1;
        lat = 0;
        while (!done16 && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w16_latency", lat, 16);
        chk("w16_sum", sum16, 16'h0000);
        chk("w16_cout", cout16, 1);
        chk("w16_ovf", ovf16, 0);
        go16 = 1'b0;
        @(posedge clk); #1;
        chk("w16_idle", state16, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
